instr_loader: RTL

//  Writer side of the instruction-memory read port used by the CPU core.

---
 rtl/instr_loader_if.sv | 28 ++
 rtl/instr_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the image loader.
//
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready
// are both high. The source holds byte_in and byte_valid steady until that
// edge; byte_ready does not depend on byte_valid. mem_we is a single-cycle
// strobe qualifying mem_addr/mem_wdata and has no back-pressure.
interface instr_loader_if #(
    parameter int D_WIDTH = 32
);
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic               mem_we;
    logic [D_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0] mem_wdata;

    // Loader side: consumes the stream, drives the memory port
    modport master (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    // Environment side: produces the stream, observes the memory port
    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Instruction image loader: assembles little-endian bytes into 32-bit words,
// writes them to consecutive word addresses and holds the CPU in reset
// until the requested number of words has been written.
module instr_loader #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [A_WIDTH:0]   i_load_len,
    instr_loader_if.master     bus,
    output logic               o_cpu_rst,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Memory depth in words, expressed in the load_len width
    localparam logic [A_WIDTH:0] LP_DEPTH = {1'b1, {A_WIDTH{1'b0}}};

    state_t               r_state;
    logic [A_WIDTH:0]     r_len;
    logic [A_WIDTH-1:0]   r_word_idx;
    logic [1:0]           r_byte_cnt;
    logic                 r_mem_we;
    logic [D_WIDTH-1:0]   r_mem_addr;
    logic [D_WIDTH-1:0]   r_mem_wdata;
    logic                 r_err;

    logic [A_WIDTH:0]     w_next_idx;
    logic                 w_byte_ready;

    // Word count after the current write; wide enough to reach the full depth
    assign w_next_idx   = {1'b0, r_word_idx} + {{A_WIDTH{1'b0}}, 1'b1};
    // No byte is taken in the cycle the assembled word is being written
    assign w_byte_ready = (r_state == ST_LOAD) && !r_mem_we;

    // Main FSM: start decoding, byte lane assembly and word write strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_byte_cnt  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        if (i_load_len == '0) begin
                            r_state <= ST_DONE;
                        end else if (i_load_len > LP_DEPTH) begin
                            // Oversized image is refused; state is left as is
                            r_err <= 1'b1;
                        end else begin
                            r_state    <= ST_LOAD;
                            r_len      <= i_load_len;
                            r_word_idx <= '0;
                            r_byte_cnt <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (r_mem_we) begin
                        r_mem_we   <= 1'b0;
                        r_byte_cnt <= '0;
                        r_word_idx <= w_next_idx[A_WIDTH-1:0];
                        if (w_next_idx == r_len) begin
                            r_state <= ST_DONE;
                        end
                    end else if (bus.byte_valid) begin
                        r_mem_wdata[8*r_byte_cnt +: 8] <= bus.byte_in;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= D_WIDTH'({r_word_idx, 2'b00});
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

    assign o_cpu_rst = (r_state != ST_DONE);
    assign o_busy    = (r_state == ST_LOAD);
    assign o_done    = (r_state == ST_DONE);
    assign o_err     = r_err;
    assign o_state   = r_state;

endmodule
